ram_sp_init: RTL and testbench
==============================

# ram_sp_init

Parametrised single-port synchronous RAM with a built-in fill engine. It is the next generation of the team's 1024x8 combinational-read RAM and adds configurable width and depth, registered reads with a valid strobe, and a hardware initialiser. The initialiser replaces bench-side fill loops. The block sits between a local master (CPU/bench driver) and on-chip storage.

## Interface
Parameters:
- DATA_W, 8, data word width (1..64)
- ADDR_W, 10, address width; depth = 2**ADDR_W (no out-of-range addresses exist)
- FILL_MODE, 1, pattern used by the fill engine:
  - 0: all zeros
  - 1: (2*addr) mod 2**DATA_W

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cs  in  1  access request, qualified each cycle
- wr  in  1  with cs: 1 = write, 0 = read
- addr  in  ADDR_W  access address
- d_in  in  DATA_W  write data
- d_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe, d_out holds new read data
- init  in  1  start-fill request, sampled in IDLE only
- busy  out  1  fill in progress, user accesses ignored
- init_done  out  1  one-cycle pulse on fill completion

## Operation
- FSM states:
  - IDLE: serves accesses; init=1 -> FILL (cnt<=0, busy<=1)
  - FILL: writes mem[cnt]=pattern(cnt) each cycle, cnt++; after writing cnt==2**ADDR_W-1 -> IDLE, busy<=0, init_done<=1 for one cycle
- IDLE access rules:
  - cs=1, wr=1: mem[addr]<=d_in at the edge; no rd_valid
  - cs=1, wr=0: d_out<=mem[addr], rd_valid<=1 next cycle
  - cs=0: no access, rd_valid<=0, d_out holds its last value
- A read of an address written in the previous cycle returns the new data.
- Simultaneous init and cs in IDLE: init wins and the access is dropped (no write, no rd_valid).
- init while in FILL is ignored. cs/wr during FILL are ignored entirely, and no rd_valid is generated.
- Fill counter is ADDR_W+1 bits wide so terminal detection is free of wrap-around. Pattern arithmetic is truncated to DATA_W.
- rst mid-FILL aborts the fill: state returns to IDLE, busy=0, no init_done. Already-written words keep their values and the rest are unchanged.
- Memory array contents are never cleared by rst. Before the first fill or write, contents are undefined (X in sim).

## Timing
- Reset values: d_out=0, rd_valid=0, busy=0, init_done=0, state=IDLE, cnt=0.
- Read latency is 1 cycle: request at edge N, d_out/rd_valid valid after edge N+1.
- Back-to-back reads are supported every cycle. rd_valid stays high continuously while cs=1, wr=0.
- Write takes effect at the sampling edge and is visible to a read issued the next cycle.
- Fill timing:
  - init sampled at edge N -> busy=1 after edge N
  - busy stays high exactly 2**ADDR_W cycles
  - init_done is high for the single cycle following the last fill write
  - busy=0 in that same cycle, and a new access is accepted in it

## Structure
- Package ram_pkg:
  - FILL_ZERO=0, FILL_DOUBLE=1 constants
  - state enum {ST_IDLE, ST_FILL}
  - pattern function fill_word(addr, mode, width)
- Sub-module ram_core: storage array mem[0:2**ADDR_W-1], one synchronous write port, one registered read port, no reset on the array.
- ram_sp_init holds the FSM, the fill counter and write-port muxing (fill vs user), and instantiates ram_core.

## Test plan
Defaults DATA_W=8, ADDR_W=10, FILL_MODE=1.
- rst then init pulse -> busy=1 for 1024 cycles, init_done pulse once. Reads of addr 0, 5, 200, 1023 -> 0, 10, 144, 254, each with rd_valid one cycle after the request.
- After fill: write 8'hA5 to addr 37, read 37 next cycle -> d_out=8'hA5; addr 38 still 76.
- Read streams 0..15 with cs held -> rd_valid high 16 consecutive cycles, d_out = 0,2,...,30.
- Assert rst at fill cycle 100 -> busy=0 next cycle, no init_done. Addr 50 reads 100, addr 500 unchanged from before the fill.
- init and cs=1, wr=1 (addr 3, 8'hFF) in the same cycle -> write dropped; after the fill, addr 3 reads 6. cs reads during FILL -> rd_valid stays 0.
- FILL_MODE=0, DATA_W=16, ADDR_W=4 -> busy=1 for 16 cycles; all 16 addresses read 16'h0000.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM with fill engine:
// fill-pattern selectors, controller state encoding and the pattern generator.
package ram_pkg;

   localparam int FILL_ZERO   = 0;
   localparam int FILL_DOUBLE = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Pattern word for one fill address, masked down to the word width so
   // callers only need to truncate the 64-bit result.
   function automatic logic [63:0] fill_word(input logic [63:0] addr,
                                             input int          mode,
                                             input int          width);
      logic [63:0] w;
      w = (mode == FILL_DOUBLE) ? (addr << 1) : 64'd0;
      for (int i = 0; i < 64; i++) begin
         if (i >= width) begin
            w[i] = 1'b0;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/ram_core.sv
// Storage array with one synchronous write port and one registered read port.
// The array itself is never reset; only the read register returns to zero.
module ram_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register holds its value whenever no read is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg <= '0;
      end else if (re) begin
         rdata_reg <= mem[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM front end: IDLE/FILL controller, fill counter and the
// write-port mux that lets the fill engine take over the storage array.
module ram_sp_init
   import ram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int FILL_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              rd_valid,
   input  logic              init,
   output logic              busy,
   output logic              init_done
);

   localparam int            CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              init_done_reg, init_done_next;
   logic              rd_valid_reg, rd_valid_next;

   logic              mem_we;
   logic              mem_re;
   logic              fill_sel;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] fill_pat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         init_done_reg <= 1'b0;
         rd_valid_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         init_done_reg <= init_done_next;
         rd_valid_reg  <= rd_valid_next;
      end
   end

   // init outranks a same-cycle access, so the access is simply not decoded.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      init_done_next = 1'b0;
      rd_valid_next  = 1'b0;
      mem_we         = 1'b0;
      mem_re         = 1'b0;
      fill_sel       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (init) begin
               state_next = ST_FILL;
               cnt_next   = '0;
            end else if (cs) begin
               if (wr) begin
                  mem_we = 1'b1;
               end else begin
                  mem_re        = 1'b1;
                  rd_valid_next = 1'b1;
               end
            end
         end
         ST_FILL: begin
            mem_we   = 1'b1;
            fill_sel = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next     = ST_IDLE;
               init_done_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // A reset edge must not land one more fill word in the array.
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   assign fill_pat  = DATA_W'(fill_word(64'(cnt_reg), FILL_MODE, DATA_W));
   assign mem_waddr = fill_sel ? cnt_reg[ADDR_W-1:0] : addr;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_wmux
         assign mem_wdata[gi] = fill_sel ? fill_pat[gi] : d_in[gi];
      end
   endgenerate

   ram_core #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (addr),
      .rdata (d_out)
   );

   assign rd_valid  = rd_valid_reg;
   assign busy      = (state_reg == ST_FILL);
   assign init_done = init_done_reg;

endmodule

// File: tb/tb_ram_sp_init.sv
// Directed bench for ram_sp_init: default 1024x8 doubling fill plus a 16x16
// zero-fill instance, with a vector table and hand-written fill sequences.
module tb_ram_sp_init;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cs, wr, init;
   logic [9:0] addr;
   logic [7:0] d_in, d_out;
   logic       rd_valid, busy, init_done;

   logic        cs2, wr2, init2;
   logic [3:0]  addr2;
   logic [15:0] d_in2, d_out2;
   logic        rd_valid2, busy2, init_done2;

   ram_sp_init #(.DATA_W(8), .ADDR_W(10), .FILL_MODE(1)) dut (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .d_in(d_in),
      .d_out(d_out), .rd_valid(rd_valid), .init(init), .busy(busy),
      .init_done(init_done)
   );

   ram_sp_init #(.DATA_W(16), .ADDR_W(4), .FILL_MODE(0)) dut2 (
      .clk(clk), .rst(rst), .cs(cs2), .wr(wr2), .addr(addr2), .d_in(d_in2),
      .d_out(d_out2), .rd_valid(rd_valid2), .init(init2), .busy(busy2),
      .init_done(init_done2)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input string name, input logic [9:0] a, input logic [7:0] exp);
      cs = 1'b1; wr = 1'b0; addr = a;
      tick();
      check({name, "_valid"}, 64'(rd_valid), 64'd1);
      check(name, 64'(d_out), 64'(exp));
      cs = 1'b0;
   endtask

   typedef struct {
      string      name;
      logic       wr;
      logic [9:0] addr;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int busy_n, done_n, guard;
      logic any_valid, busy_dropped, done_seen;

      vecs[0] = '{"rd_0",    1'b0, 10'd0,    8'h00, 8'd0};
      vecs[1] = '{"rd_5",    1'b0, 10'd5,    8'h00, 8'd10};
      vecs[2] = '{"rd_200",  1'b0, 10'd200,  8'h00, 8'd144};
      vecs[3] = '{"rd_1023", 1'b0, 10'd1023, 8'h00, 8'd254};
      vecs[4] = '{"rd_3",    1'b0, 10'd3,    8'h00, 8'd6};
      vecs[5] = '{"rd_500",  1'b0, 10'd500,  8'h00, 8'hE8};
      vecs[6] = '{"wr_37",   1'b1, 10'd37,   8'hA5, 8'h00};
      vecs[7] = '{"rd_37",   1'b0, 10'd37,   8'h00, 8'hA5};
      vecs[8] = '{"rd_38",   1'b0, 10'd38,   8'h00, 8'd76};
      vecs[9] = '{"rd_99",   1'b0, 10'd99,   8'h00, 8'd198};

      rst = 1'b1; cs = 1'b0; wr = 1'b0; init = 1'b0; addr = '0; d_in = '0;
      cs2 = 1'b0; wr2 = 1'b0; init2 = 1'b0; addr2 = '0; d_in2 = '0;
      tick(); tick();
      check("rst_d_out",      64'(d_out),      64'd0);
      check("rst_rd_valid",   64'(rd_valid),   64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_init_done",  64'(init_done),  64'd0);
      check("rst2_d_out",     64'(d_out2),     64'd0);
      check("rst2_busy",      64'(busy2),      64'd0);
      rst = 1'b0;

      // Seed two words that the aborted fill must (50) and must not (500) reach.
      cs = 1'b1; wr = 1'b1; addr = 10'd500; d_in = 8'h3C; tick();
      addr = 10'd50; d_in = 8'h11; tick();
      cs = 1'b0;
      check("wr_no_valid", 64'(rd_valid), 64'd0);
      read_chk("pre_500", 10'd500, 8'h3C);

      // init with a simultaneous write to 500, then reset after 100 fill writes.
      init = 1'b1; cs = 1'b1; wr = 1'b1; addr = 10'd500; d_in = 8'hFF;
      tick();
      check("abort_busy_start", 64'(busy), 64'd1);
      check("abort_no_valid0",  64'(rd_valid), 64'd0);
      init = 1'b0; wr = 1'b0; addr = 10'd0;
      any_valid = 1'b0; busy_dropped = 1'b0;
      repeat (100) begin
         tick();
         if (rd_valid !== 1'b0) any_valid = 1'b1;
         if (busy !== 1'b1) busy_dropped = 1'b1;
      end
      check("abort_fill_no_valid", 64'(any_valid), 64'd0);
      check("abort_busy_held",     64'(busy_dropped), 64'd0);
      rst = 1'b1; cs = 1'b0;
      tick();
      rst = 1'b0;
      check("abort_busy_low", 64'(busy), 64'd0);
      done_seen = init_done;
      repeat (4) begin
         tick();
         if (init_done !== 1'b0) done_seen = 1'b1;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);
      read_chk("abort_50",  10'd50,  8'd100);
      read_chk("abort_99",  10'd99,  8'd198);
      read_chk("abort_500", 10'd500, 8'h3C);

      // Full fill: init collides with a write to 3, reads and repeated init during FILL.
      init = 1'b1; cs = 1'b1; wr = 1'b1; addr = 10'd3; d_in = 8'hFF;
      tick();
      check("fill_busy_start", 64'(busy), 64'd1);
      check("fill_no_valid0",  64'(rd_valid), 64'd0);
      wr = 1'b0; addr = 10'd7;
      busy_n = 1; done_n = 0; guard = 0; any_valid = 1'b0;
      while (busy === 1'b1 && guard < 3000) begin
         if (busy_n >= 500) init = 1'b0;
         tick();
         guard++;
         if (busy === 1'b1) busy_n++;
         if (init_done === 1'b1) done_n++;
         if (rd_valid !== 1'b0) any_valid = 1'b1;
      end
      init = 1'b0;
      check("fill_finished",    64'(busy), 64'd0);
      check("fill_busy_cycles", 64'(busy_n), 64'd1024);
      check("fill_done_now",    64'(init_done), 64'd1);
      check("fill_done_count",  64'(done_n), 64'd1);
      check("fill_no_valid",    64'(any_valid), 64'd0);
      addr = 10'd5;
      tick();
      check("done_cycle_rd_valid", 64'(rd_valid), 64'd1);
      check("done_cycle_rd_data",  64'(d_out), 64'd10);
      check("done_pulse_width",    64'(init_done), 64'd0);
      cs = 1'b0;

      foreach (vecs[i]) begin
         cs = 1'b1; wr = vecs[i].wr; addr = vecs[i].addr; d_in = vecs[i].din;
         tick();
         if (vecs[i].wr) begin
            check({vecs[i].name, "_valid"}, 64'(rd_valid), 64'd0);
         end else begin
            check({vecs[i].name, "_valid"}, 64'(rd_valid), 64'd1);
            check(vecs[i].name, 64'(d_out), 64'(vecs[i].exp));
         end
      end
      cs = 1'b0; addr = 10'd0;
      tick();
      check("idle_valid_low", 64'(rd_valid), 64'd0);
      check("idle_d_out_hold", 64'(d_out), 64'd198);

      for (int i = 0; i < 16; i++) begin
         cs = 1'b1; wr = 1'b0; addr = 10'(i);
         tick();
         check($sformatf("stream_valid_%0d", i), 64'(rd_valid), 64'd1);
         check($sformatf("stream_data_%0d", i), 64'(d_out), 64'(2 * i));
      end
      cs = 1'b0;

      // Second instance: 16-word zero fill.
      init2 = 1'b1;
      tick();
      init2 = 1'b0;
      check("z_busy_start", 64'(busy2), 64'd1);
      busy_n = 1; done_n = 0; guard = 0;
      while (busy2 === 1'b1 && guard < 100) begin
         tick();
         guard++;
         if (busy2 === 1'b1) busy_n++;
         if (init_done2 === 1'b1) done_n++;
      end
      check("z_busy_cycles", 64'(busy_n), 64'd16);
      check("z_done_count",  64'(done_n), 64'd1);
      for (int i = 0; i < 16; i++) begin
         cs2 = 1'b1; wr2 = 1'b0; addr2 = 4'(i);
         tick();
         check($sformatf("z_valid_%0d", i), 64'(rd_valid2), 64'd1);
         check($sformatf("z_data_%0d", i), 64'(d_out2), 64'h0000);
      end
      cs2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
